// File: rtl/acc_shift_reg.sv
// Running-product accumulator for the sequential multiplier. It holds, clears, loads or
// accumulates a shifted partial product, and tracks sticky overflow and a saturating op count.
module acc_shift_reg #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned STEP     = 4,
    parameter int unsigned SHIFT_W  = 2,
    parameter int unsigned CNT_W    = 3
) (
    input  logic                clk,
    input  logic                sclr,
    input  logic                clk_ena,
    input  logic [1:0]          op,
    input  logic [SHIFT_W-1:0]  shift_sel,
    input  logic [IN_WIDTH-1:0] datain,
    output logic [WIDTH-1:0]    reg_out,
    output logic                ovf,
    output logic [CNT_W-1:0]    acc_count,
    output logic                is_zero
);

    // Wide enough that the largest shifted operand never loses bits before the lost check.
    localparam int unsigned OPND_W = WIDTH + IN_WIDTH + (2**SHIFT_W - 1) * STEP;

    localparam logic [1:0] OP_HOLD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_ACC   = 2'b11;

    logic [WIDTH-1:0]  r_reg;
    logic              r_ovf;
    logic [CNT_W-1:0]  r_cnt;

    logic [31:0]       w_shamt;
    logic [OPND_W-1:0] w_opnd;
    logic              w_lost;
    logic [WIDTH:0]    w_sum;

    assign w_shamt = 32'(shift_sel) * STEP;
    assign w_opnd  = {{(OPND_W - IN_WIDTH){1'b0}}, datain} << w_shamt;
    assign w_lost  = |w_opnd[OPND_W-1:WIDTH];
    assign w_sum   = {1'b0, r_reg} + {1'b0, w_opnd[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_reg <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (clk_ena) begin
            case (op)
                OP_CLEAR: begin
                    r_reg <= '0;
                    r_ovf <= 1'b0;
                    r_cnt <= '0;
                end
                OP_LOAD: begin
                    r_reg <= w_opnd[WIDTH-1:0];
                    r_ovf <= w_lost;
                    r_cnt <= '0;
                end
                OP_ACC: begin
                    r_reg <= w_sum[WIDTH-1:0];
                    r_ovf <= r_ovf | w_sum[WIDTH] | w_lost;
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                OP_HOLD: ;
                default: ;  // unknown op holds state
            endcase
        end
    end

    assign reg_out   = r_reg;
    assign ovf       = r_ovf;
    assign acc_count = r_cnt;
    assign is_zero   = (r_reg == '0);

endmodule

// File: tb/tb_acc_shift_reg.sv
// Scoreboard bench for acc_shift_reg: expected state is queued as each operation is driven
// and checked one cycle later, when the registered result appears.
module tb_acc_shift_reg;

    typedef struct packed {
        logic        s;
        logic        e;
        logic [1:0]  op;
        logic [1:0]  sh;
        logic [7:0]  d;
        logic [15:0] r;
        logic        o;
        logic [2:0]  c;
    } row_t;

    logic        clk = 1'b0;
    logic        sclr;
    logic        clk_ena;
    logic [1:0]  op;
    logic [1:0]  shift_sel;
    logic [7:0]  datain;
    logic [15:0] reg_out;
    logic        ovf;
    logic [2:0]  acc_count;
    logic        is_zero;

    int   total = 0;
    int   bad   = 0;
    row_t q_exp[$];

    acc_shift_reg #(
        .WIDTH    (16),
        .IN_WIDTH (8),
        .STEP     (4),
        .SHIFT_W  (2),
        .CNT_W    (3)
    ) dut (
        .clk       (clk),
        .sclr      (sclr),
        .clk_ena   (clk_ena),
        .op        (op),
        .shift_sel (shift_sel),
        .datain    (datain),
        .reg_out   (reg_out),
        .ovf       (ovf),
        .acc_count (acc_count),
        .is_zero   (is_zero)
    );

    always #5 clk = ~clk;

    // Apply one operation, queue its expected result, and return 1 time unit after the edge.
    task automatic drive(input row_t rw);
        sclr      = rw.s;
        clk_ena   = rw.e;
        op        = rw.op;
        shift_sel = rw.sh;
        datain    = rw.d;
        q_exp.push_back(rw);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows [4];
        row_t ex;
        rows[0] = '{1'b1, 1'b1, 2'b10, 2'd0, 8'hAB, 16'h0000, 1'b0, 3'd0};
        rows[1] = '{1'b0, 1'b1, 2'b10, 2'd0, 8'h12, 16'h0012, 1'b0, 3'd0};
        rows[2] = '{1'b1, 1'b0, 2'b10, 2'd0, 8'hAB, 16'h0000, 1'b0, 3'd0};
        rows[3] = '{1'b0, 1'b1, 2'b00, 2'd0, 8'hAB, 16'h0000, 1'b0, 3'd0};
        for (int i = 0; i < 4; i++) begin
            drive(rows[i]);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL reset[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    task automatic test_multiply();
        row_t rows [4];
        row_t ex;
        rows[0] = '{1'b0, 1'b1, 2'b10, 2'd0, 8'hE1, 16'h00E1, 1'b0, 3'd0};
        rows[1] = '{1'b0, 1'b1, 2'b11, 2'd1, 8'hE1, 16'h0EF1, 1'b0, 3'd1};
        rows[2] = '{1'b0, 1'b1, 2'b11, 2'd1, 8'hE1, 16'h1D01, 1'b0, 3'd2};
        rows[3] = '{1'b0, 1'b1, 2'b11, 2'd2, 8'hE1, 16'hFE01, 1'b0, 3'd3};
        for (int i = 0; i < 4; i++) begin
            drive(rows[i]);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL multiply[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    task automatic test_enable_gating();
        row_t rows [6];
        row_t ex;
        rows[0] = '{1'b0, 1'b1, 2'b10, 2'd0, 8'h34, 16'h0034, 1'b0, 3'd0};
        rows[1] = '{1'b0, 1'b1, 2'b11, 2'd2, 8'h12, 16'h1234, 1'b0, 3'd1};
        rows[2] = '{1'b0, 1'b0, 2'b11, 2'd0, 8'hFF, 16'h1234, 1'b0, 3'd1};
        rows[3] = '{1'b0, 1'b0, 2'b11, 2'd0, 8'hFF, 16'h1234, 1'b0, 3'd1};
        rows[4] = '{1'b0, 1'b0, 2'b11, 2'd0, 8'hFF, 16'h1234, 1'b0, 3'd1};
        rows[5] = '{1'b0, 1'b0, 2'bxx, 2'd3, 8'hFF, 16'h1234, 1'b0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i]);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL enable[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    task automatic test_overflow();
        row_t rows [9];
        row_t ex;
        rows[0] = '{1'b0, 1'b1, 2'b10, 2'd3, 8'hFF, 16'hF000, 1'b1, 3'd0};
        rows[1] = '{1'b0, 1'b1, 2'b01, 2'd0, 8'hFF, 16'h0000, 1'b0, 3'd0};
        rows[2] = '{1'b0, 1'b1, 2'b10, 2'd2, 8'hFF, 16'hFF00, 1'b0, 3'd0};
        rows[3] = '{1'b0, 1'b1, 2'b11, 2'd0, 8'hFF, 16'hFFFF, 1'b0, 3'd1};
        rows[4] = '{1'b0, 1'b1, 2'b11, 2'd0, 8'h01, 16'h0000, 1'b1, 3'd2};
        rows[5] = '{1'b0, 1'b1, 2'b11, 2'd0, 8'h05, 16'h0005, 1'b1, 3'd3};
        rows[6] = '{1'b0, 1'b1, 2'b00, 2'd0, 8'h77, 16'h0005, 1'b1, 3'd3};
        rows[7] = '{1'b0, 1'b1, 2'b11, 2'd3, 8'h10, 16'h0005, 1'b1, 3'd4};
        rows[8] = '{1'b0, 1'b1, 2'b10, 2'd0, 8'h01, 16'h0001, 1'b0, 3'd0};
        for (int i = 0; i < 9; i++) begin
            drive(rows[i]);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL overflow[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    task automatic test_count_saturation();
        row_t rows [13];
        row_t ex;
        rows[0] = '{1'b0, 1'b1, 2'b01, 2'd0, 8'h00, 16'h0000, 1'b0, 3'd0};
        for (int i = 1; i <= 9; i++) begin
            rows[i] = '{1'b0, 1'b1, 2'b11, 2'd0, 8'h01, 16'(i), 1'b0, (i > 7) ? 3'd7 : 3'(i)};
        end
        rows[10] = '{1'b0, 1'b1, 2'b10, 2'd0, 8'h03, 16'h0003, 1'b0, 3'd0};
        rows[11] = '{1'b0, 1'b1, 2'b11, 2'd1, 8'h02, 16'h0023, 1'b0, 3'd1};
        rows[12] = '{1'b1, 1'b1, 2'b11, 2'd1, 8'h02, 16'h0000, 1'b0, 3'd0};
        for (int i = 0; i < 13; i++) begin
            drive(rows[i]);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL count[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    // Random back-to-back operations against an integer reference of the arithmetic.
    task automatic test_back_to_back();
        int unsigned m_r = 0;
        int unsigned m_c = 0;
        logic        m_o = 1'b0;
        int unsigned opnd;
        int unsigned sum;
        row_t        rw;
        row_t        ex;
        drive('{1'b1, 1'b0, 2'b00, 2'd0, 8'h00, 16'h0000, 1'b0, 3'd0});
        ex = q_exp.pop_front();
        for (int i = 0; i < 60; i++) begin
            rw.s  = ($urandom_range(0, 15) == 0);
            rw.e  = ($urandom_range(0, 3) != 0);
            rw.op = 2'($urandom_range(0, 3));
            rw.sh = 2'($urandom_range(0, 3));
            rw.d  = 8'($urandom_range(0, 255));
            opnd  = 32'(rw.d) << (32'(rw.sh) * 4);
            if (rw.s) begin
                m_r = 0; m_o = 1'b0; m_c = 0;
            end else if (rw.e) begin
                if (rw.op == 2'b01) begin
                    m_r = 0; m_o = 1'b0; m_c = 0;
                end else if (rw.op == 2'b10) begin
                    m_r = opnd & 32'hFFFF; m_o = ((opnd >> 16) != 0); m_c = 0;
                end else if (rw.op == 2'b11) begin
                    sum = m_r + (opnd & 32'hFFFF);
                    m_o = m_o | ((sum >> 16) != 0) | ((opnd >> 16) != 0);
                    m_r = sum & 32'hFFFF;
                    if (m_c < 7) m_c = m_c + 1;
                end
            end
            rw.r = 16'(m_r);
            rw.o = m_o;
            rw.c = 3'(m_c);
            drive(rw);
            ex = q_exp.pop_front();
            total++;
            if ({reg_out, ovf, acc_count, is_zero} !== {ex.r, ex.o, ex.c, (ex.r == 16'h0)}) begin
                bad++;
                $display("FAIL random[%0d]: got reg=%h ovf=%b cnt=%0d z=%b, want reg=%h ovf=%b cnt=%0d z=%b",
                         i, reg_out, ovf, acc_count, is_zero, ex.r, ex.o, ex.c, (ex.r == 16'h0));
            end
        end
    endtask

    initial begin
        sclr      = 1'b1;
        clk_ena   = 1'b0;
        op        = 2'b00;
        shift_sel = 2'd0;
        datain    = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_multiply();
        test_enable_gating();
        test_overflow();
        test_count_saturation();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_shift_reg.md
Name: acc_shift_reg

Overview:
- Parametrised successor of the team's 16-bit clear/enable register, for the sequential multiplier datapath.
- Holds the running product. It can hold, clear, load or accumulate an IN_WIDTH partial product, pre-shifted left by a selectable multiple of STEP bits.
- Also tracks a sticky overflow flag and a saturating count of accumulate operations, which the multiplier controller uses to detect completion.
- Sits between the partial-product multiplier and the product output.

Parameters:
- WIDTH, 16: width of the accumulator register and of reg_out.
- IN_WIDTH, 8: width of datain (partial product); must satisfy IN_WIDTH <= WIDTH.
- STEP, 4: shift granularity in bits; shift amount = shift_sel * STEP.
- SHIFT_W, 2: width of shift_sel.
- CNT_W, 3: width of acc_count.

Ports:
- clk  input  1  rising-edge clock, sole clock.
- sclr  input  1  synchronous active-high reset.
- clk_ena  input  1  operation enable; when 0 all state holds.
- op  input  2  00 hold, 01 clear, 10 load, 11 accumulate.
- shift_sel  input  SHIFT_W  operand shift select, in units of STEP bits.
- datain  input  IN_WIDTH  partial-product operand.
- reg_out  output  WIDTH  accumulator contents, registered.
- ovf  output  1  sticky overflow flag, registered.
- acc_count  output  CNT_W  number of accumulates since last clear/load, saturating, registered.
- is_zero  output  1  combinational, reg_out == 0.

Behaviour:
- Reset: clock is clk; reset is synchronous and active-high. sclr=1 at a rising edge sets reg_out=0, ovf=0, acc_count=0.
  - sclr has priority over clk_ena and op.
  - sclr asserted mid-sequence discards all partial results.
- clk_ena=0 (sclr=0): reg_out, ovf and acc_count hold regardless of op.
- Operand formation:
  - opnd = zero-extend(datain) << (shift_sel*STEP), computed at width WIDTH+IN_WIDTH+(2^SHIFT_W-1)*STEP.
  - The operand applied to the register is opnd[WIDTH-1:0].
  - lost = (opnd bits at or above WIDTH are nonzero).
- op=00 hold: no state change.
- op=01 clear: reg_out=0, ovf=0, acc_count=0.
- op=10 load: reg_out=opnd[WIDTH-1:0], ovf=lost, acc_count=0.
- op=11 accumulate:
  - sum = reg_out + opnd[WIDTH-1:0], computed at WIDTH+1 bits.
  - reg_out = sum[WIDTH-1:0] (wraps modulo 2^WIDTH).
  - ovf = ovf | sum[WIDTH] | lost.
  - acc_count = acc_count+1, saturating at 2^CNT_W-1; it does not wrap.
- Latency: one cycle. Result visible on reg_out the cycle after the enabled edge; is_zero follows reg_out combinationally.
- ovf is sticky. It is cleared only by sclr, clear, or a load with lost=0.
- Unsigned arithmetic only; no sign extension.
- X on op while clk_ena=0 must not corrupt state.

Test Plan:
- Reset: drive sclr=1 with clk_ena=1, op=10, datain=0xAB -> next cycle reg_out=0x0000, ovf=0, acc_count=0, is_zero=1. Repeat with clk_ena=0 -> same result.
- 8x8 multiply 0xFF*0xFF via four 4x4 partial products, each datain=0xE1:
  - load shift_sel=0, then accumulate shift_sel=1, accumulate shift_sel=1, accumulate shift_sel=2.
  - Required: reg_out sequence 0x00E1, 0x0EF1, 0x1D01, 0xFE01; final acc_count=3, ovf=0.
- Enable gating: after reg_out=0x1234, hold clk_ena=0 for 3 cycles with op=11, datain=0xFF -> reg_out stays 0x1234 and acc_count unchanged.
- Truncation overflow: load datain=0xFF, shift_sel=3 -> reg_out=0xF000, ovf=1. Then clear -> reg_out=0, ovf=0.
- Carry overflow and stickiness:
  - load 0xFF shift_sel=2 -> 0xFF00.
  - accumulate 0xFF shift_sel=0 -> 0xFFFF, ovf=0.
  - accumulate 0x01 -> reg_out=0x0000, ovf=1, is_zero=1.
  - accumulate 0x05 -> reg_out=0x0005, ovf stays 1.
- Count saturation: clear, then 9 accumulates of 0x01 -> acc_count reaches 7 and holds; reg_out=0x0009. A following load -> acc_count=0.
